// File: rtl/ks8_accum_sequencer.sv
// ks8_accum_sequencer: 16-bit MAC accumulator built from two passes through one 8-bit Kogge-Stone adder.
// 3 cycles per product (accept, low byte, high byte); in_ready only in WAIT_IN, result held until out_ready.

module ks8_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [7:0] p0, g0, g1, p1, g2, p2, g3;

  assign p0 = a ^ b;
  // cin is folded into the bit-0 generate so the prefix tree yields carries directly
  assign g0 = {a[7:1] & b[7:1], (a[0] & b[0]) | (p0[0] & cin)};
  assign g1 = g0 | (p0 & {g0[6:0], 1'b0});
  assign p1 = p0 & {p0[6:0], 1'b1};
  assign g2 = g1 | (p1 & {g1[5:0], 2'b00});
  assign p2 = p1 & {p1[5:0], 2'b11};
  assign g3 = g2 | (p2 & {g2[3:0], 4'h0});
  assign s    = p0 ^ {g3[6:0], cin};
  assign cout = g3[7];
endmodule

module ks8_accum_sequencer #(
  parameter int N_TERMS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] init_acc,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_acc,
  output logic        out_ovf,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, WAIT_IN, ADD_LO, ADD_HI, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

  state_t      state, state_nxt;
  logic [15:0] acc;
  logic [7:0]  cnt;
  logic [7:0]  operand;
  logic        carry_r;
  logic        ovf;
  logic [7:0]  add_a, add_b, add_s;
  logic        add_cin, add_cout;

  ks8_adder u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  // Adder operands are parked at zero outside the two add states to keep it quiet
  always_comb begin
    state_nxt = state;
    add_a     = 8'h00;
    add_b     = 8'h00;
    add_cin   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_acc   = 16'h0000;
    out_ovf   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = WAIT_IN;
      end
      WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ADD_LO;
      end
      ADD_LO: begin
        add_a     = acc[7:0];
        add_b     = operand;
        state_nxt = ADD_HI;
      end
      ADD_HI: begin
        add_a     = acc[15:8];
        add_cin   = carry_r;
        state_nxt = (cnt == LAST_CNT) ? DONE : WAIT_IN;
      end
      DONE: begin
        out_valid = 1'b1;
        out_acc   = acc;
        out_ovf   = ovf;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= 16'h0000;
      cnt     <= 8'h00;
      operand <= 8'h00;
      carry_r <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= init_acc;
            cnt <= 8'h00;
            ovf <= 1'b0;
          end
        end
        WAIT_IN: begin
          if (in_valid) operand <= in_data;
        end
        ADD_LO: begin
          acc[7:0] <= add_s;
          carry_r  <= add_cout;
        end
        ADD_HI: begin
          acc[15:8] <= add_s;
          if (add_cout) ovf <= 1'b1;
          if (cnt != LAST_CNT) cnt <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ks8_accum_sequencer.sv
// Bench for ks8_accum_sequencer: instance 0 runs N_TERMS=4, instance 1 runs N_TERMS=1.
// A per-cycle compare process holds a plain-arithmetic running-sum model of each job.
module tb_ks8_accum_sequencer;
  logic        clk;
  logic        rst_n;
  logic        start     [2];
  logic [15:0] init_acc  [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  in_data   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_acc   [2];
  logic        out_ovf   [2];
  logic        busy      [2];

  int total;
  int bad;

  int   exp_acc [2];
  logic exp_ovf [2];
  int   nacc    [2];

  logic [7:0] pq[$];

  ks8_accum_sequencer #(.N_TERMS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .init_acc(init_acc[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_acc(out_acc[0]),
    .out_ovf(out_ovf[0]), .busy(busy[0])
  );

  ks8_accum_sequencer #(.N_TERMS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .init_acc(init_acc[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_acc(out_acc[1]),
    .out_ovf(out_ovf[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nt(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Model: a job is the 16-bit wrapped sum of init and accepted products; ovf is set
  // whenever the running 16-bit sum passes 0xFFFF.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk("rst_outputs", {in_ready[k], out_valid[k], out_ovf[k], busy[k], out_acc[k]}, 32'h0);
        nacc[k] <= 0;
      end else begin
        if (out_valid[k]) begin
          chk("out_acc", {16'h0, out_acc[k]}, exp_acc[k]);
          chk("out_ovf", {31'h0, out_ovf[k]}, {31'h0, exp_ovf[k]});
          chk("terms_taken", nacc[k], nt(k));
          chk("done_flags", {busy[k], in_ready[k]}, 2'b10);
        end
        if (in_ready[k])
          chk("ready_flags", {busy[k], out_valid[k]}, 2'b10);
        if (start[k] && !busy[k]) begin
          exp_acc[k] <= init_acc[k];
          exp_ovf[k] <= 1'b0;
          nacc[k]    <= 0;
        end else if (in_valid[k] && in_ready[k]) begin
          chk("accept_in_budget", {31'h0, nacc[k] < nt(k)}, 1);
          exp_acc[k] <= (exp_acc[k] + int'(in_data[k])) & 'hFFFF;
          exp_ovf[k] <= exp_ovf[k] | ((exp_acc[k] + int'(in_data[k])) > 'hFFFF);
          nacc[k]    <= nacc[k] + 1;
        end
      end
    end
  end

  task automatic do_job(input int k, input logic [15:0] init, input int gap, input int stall,
                        input bit poke, output logic [15:0] racc, output logic rovf, output int lat);
    int guard;
    bit hs;
    bit poked;
    init_acc[k] = init;
    start[k]    = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    lat      = 1;
    guard    = 0;
    poked    = 1'b0;
    chk("busy_after_start", {busy[k], in_ready[k]}, 2'b11);
    while (!out_valid[k] && guard < 400) begin
      if (!in_ready[k]) begin
        in_valid[k] = 1'($urandom);
        in_data[k]  = 8'($urandom);
      end else if (pq.size() > 0 && $urandom_range(99) >= gap) begin
        in_valid[k] = 1'b1;
        in_data[k]  = pq[0];
      end else begin
        in_valid[k] = 1'b0;
        in_data[k]  = 8'($urandom);
      end
      hs = in_valid[k] && in_ready[k];
      @(posedge clk); #1;
      lat++;
      guard++;
      start[k] = 1'b0;
      if (hs) begin
        void'(pq.pop_front());
        if (poke && !poked) begin
          start[k]    = 1'b1;
          init_acc[k] = 16'($urandom);
          poked       = 1'b1;
        end
      end
    end
    in_valid[k] = 1'b0;
    chk("job_done", {31'h0, out_valid[k]}, 1);
    racc = out_acc[k];
    rovf = out_ovf[k];
    for (int i = 0; i < stall; i++) begin
      start[k] = poke && (i == 1);
      @(posedge clk); #1;
      start[k] = 1'b0;
      chk("stall_hold", {out_valid[k], busy[k], out_acc[k], out_ovf[k]}, {13'h0, 2'b11, racc, rovf});
    end
    out_ready[k] = 1'b1;
    start[k]     = poke;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    start[k]     = 1'b0;
    chk("idle_after_ack", {busy[k], out_valid[k]}, 2'b00);
  endtask

  initial begin
    logic [15:0] ra;
    logic        ro;
    int          lat;
    int          n;
    int          g;
    bit          hs;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; init_acc[k] = 16'h0; in_valid[k] = 1'b0;
      in_data[k] = 8'h0; out_ready[k] = 1'b0;
      exp_acc[k] = 0; exp_ovf[k] = 1'b0; nacc[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_in_ready", {31'h0, in_ready[k]}, 0);
      chk("reset_out_valid", {31'h0, out_valid[k]}, 0);
      chk("reset_out_acc", {16'h0, out_acc[k]}, 0);
      chk("reset_busy", {31'h0, busy[k]}, 0);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    pq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_job(0, 16'h0000, 0, 0, 1'b0, ra, ro, lat);
    chk("ff4_acc", {16'h0, ra}, 32'h03FC);
    chk("ff4_ovf", {31'h0, ro}, 0);
    chk("ff4_latency", lat, 13);

    pq = '{8'h10, 8'h01, 8'h00, 8'hFF};
    do_job(0, 16'h00F0, 0, 1, 1'b0, ra, ro, lat);
    chk("carry_acc", {16'h0, ra}, 32'h0200);
    chk("carry_ovf", {31'h0, ro}, 0);

    pq = '{8'h20};
    do_job(1, 16'hFFF0, 0, 0, 1'b0, ra, ro, lat);
    chk("wrap_acc", {16'h0, ra}, 32'h0010);
    chk("wrap_ovf", {31'h0, ro}, 1);
    chk("n1_latency", lat, 4);
    pq = '{8'h01};
    do_job(1, 16'h0000, 0, 0, 1'b0, ra, ro, lat);
    chk("ovf_clear_acc", {16'h0, ra}, 32'h0001);
    chk("ovf_clear_ovf", {31'h0, ro}, 0);

    pq = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    do_job(0, 16'($urandom), 40, 5, 1'b0, ra, ro, lat);

    pq = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_job(0, 16'h1234, 20, 3, 1'b1, ra, ro, lat);
    chk("poke_acc", {16'h0, ra}, 32'h123E);
    chk("poke_ovf", {31'h0, ro}, 0);

    // Async reset landing in ADD_HI of the second term
    pq.delete();
    init_acc[0] = 16'h5555;
    start[0]    = 1'b1;
    @(posedge clk); #1;
    start[0]    = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h77;
    n = 0;
    g = 0;
    while (n < 2 && g < 50) begin
      hs = in_valid[0] && in_ready[0];
      @(posedge clk); #1;
      g++;
      if (hs) n++;
    end
    in_valid[0] = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_state", {busy[0], in_ready[0], out_valid[0]}, 3'b100);
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'h0, in_ready[0]}, 0);
    chk("rst_out_valid", {31'h0, out_valid[0]}, 0);
    chk("rst_out_acc", {16'h0, out_acc[0]}, 0);
    chk("rst_out_ovf", {31'h0, out_ovf[0]}, 0);
    chk("rst_busy", {31'h0, busy[0]}, 0);
    @(posedge clk);
    @(posedge clk); #4;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {busy[0], out_valid[0]}, 2'b00);
    pq = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_job(0, 16'h0100, 0, 0, 1'b0, ra, ro, lat);
    chk("after_rst_acc", {16'h0, ra}, 32'h01AA);
    chk("after_rst_ovf", {31'h0, ro}, 0);
    chk("after_rst_latency", lat, 13);

    for (int j = 0; j < 6; j++) begin
      pq = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      do_job(0, 16'($urandom), 30, int'($urandom_range(5)), 1'(j % 2), ra, ro, lat);
      pq = '{8'($urandom)};
      do_job(1, 16'($urandom_range(16'hFFFF, 16'hFF00)), 30, int'($urandom_range(3)), 1'b0, ra, ro, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ks8_accum_sequencer.md
# ks8_accum_sequencer

Multi-cycle accumulation controller that shares one 8-bit Kogge-Stone adder instance to build a 16-bit MAC accumulator. It accepts a stream of 8-bit products from the 4-bit multiplier stage over a valid/ready handshake. Each product is added in two adder passes: low byte, then high byte with the stored carry. After `N_TERMS` products it presents the 16-bit sum and a sticky overflow flag downstream.

## Interface
- `N_TERMS`, default 4: number of products accumulated per job; legal range 1..255.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: job start pulse; honoured only in IDLE.
- `init_acc` input 16: accumulator preload, sampled with `start`.
- `in_valid` input 1: product available.
- `in_ready` output 1: sequencer can take a product.
- `in_data` input 8: unsigned 4x4 product.
- `out_valid` output 1: result available.
- `out_ready` input 1: downstream accepts the result.
- `out_acc` output 16: accumulated sum, modulo 2^16.
- `out_ovf` output 1: sticky; set if any high-byte pass produced carry-out.
- `busy` output 1: high in every state except IDLE.

## Operation
- Exactly one Kogge-Stone 8-bit adder instance (`a`, `b`, `cin`, `s`, `cout`). No other adders for accumulation.
- The term counter is 8 bits.
- FSM states: IDLE, WAIT_IN, ADD_LO, ADD_HI, DONE.
- IDLE:
  - `in_ready`=0.
  - On `start`=1: acc<=`init_acc`, cnt<=0, ovf<=0, go to WAIT_IN.
- WAIT_IN:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: operand register<=`in_data`, go to ADD_LO.
- ADD_LO:
  - Adder inputs: a=acc[7:0], b=operand, cin=0.
  - acc[7:0]<=s, carry_r<=cout, go to ADD_HI.
- ADD_HI:
  - Adder inputs: a=acc[15:8], b=8'h00, cin=carry_r.
  - acc[15:8]<=s. If cout=1, ovf<=1.
  - If cnt==N_TERMS-1, go to DONE. Otherwise cnt<=cnt+1 and go to WAIT_IN.
- DONE:
  - `out_valid`=1; `out_acc`=acc; `out_ovf`=ovf.
  - On `out_ready`: go to IDLE.
- In any other state, adder inputs are driven to 0 so the adder does not toggle.
- `start` outside IDLE is ignored; it has no effect on acc, cnt or ovf.
- `in_data` presented outside WAIT_IN is never sampled.
- Overflow wraps: the sum is kept modulo 2^16 and ovf stays set until the next `start`.

## Timing
- Reset values:
  - state=IDLE.
  - acc=0, cnt=0, carry_r=0, ovf=0, operand=0.
  - Outputs: `in_ready`=0, `out_valid`=0, `out_acc`=0, `out_ovf`=0, `busy`=0.
- All outputs are registered state decodes; there is no combinational path from input to output.
- `start` sampled at edge T: `busy` and `in_ready` are high from T+1.
- Per-term cost is 3 cycles minimum (accept, ADD_LO, ADD_HI). The next `in_ready` rises 2 cycles after the accept edge.
- Job latency with `in_valid` held high: 1 + 3·N_TERMS cycles from `start` edge to `out_valid`.
- `out_valid` holds, and `out_acc`/`out_ovf` stay stable, until the `out_ready` edge. IDLE is entered on the next cycle.
- A `start` in the same cycle as the DONE->IDLE transition is ignored; it must be reasserted in IDLE.
- Reset asserted mid-job:
  - Immediate return to reset values.
  - The partial sum is discarded and no `out_valid` is produced.
  - An in-flight product is lost.

## Test plan
- N_TERMS=4, `init_acc`=0, four products 8'hFF back-to-back -> `out_acc`=16'h03FC, `out_ovf`=0, `out_valid` 13 cycles after `start`.
- N_TERMS=4, `init_acc`=16'h00F0, products 8'h10,8'h01,8'h00,8'hFF -> low-byte carry into high byte on term 1; `out_acc`=16'h0200, `out_ovf`=0.
- N_TERMS=1, `init_acc`=16'hFFF0, product 8'h20 -> `out_acc`=16'h0010, `out_ovf`=1. A following job with `init_acc`=0 and product 8'h01 -> `out_acc`=16'h0001, `out_ovf`=0.
- N_TERMS=4, `in_valid` toggling with random gaps and `out_ready` held low for 5 cycles in DONE -> correct sum. No product is accepted outside WAIT_IN. `out_acc` is stable while stalled.
- `start` pulsed during ADD_LO and during DONE -> ignored; result unchanged; `busy` stays high.
- `rst_n` dropped asynchronously during ADD_HI of term 2 -> all outputs 0 immediately. A fresh job after release gives the correct sum.
